// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/ME memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_ME = 1'b1;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the IF and ME stages; freezes the
// pipeline until every active request has completed once.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [31:0]       me_addr,
    input  logic [31:0]       me_wdata,
    output logic              me_ready,
    output logic [31:0]       me_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic                winner_q, winner_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                if_done_q, if_done_d;
    logic                me_done_q, me_done_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         me_rdata_q, me_rdata_d;

    logic if_elig, me_elig, grant_me;
    logic if_done_set, me_done_set;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                me_addr[31:ADDR_W+2], me_addr[1:0]};

    assign if_elig = if_req & ~if_done_q;
    assign me_elig = me_req & ~me_done_q;
    assign stall   = if_elig | me_elig;

    // ME normally wins; IF takes the slot once it has been passed over STARVE_MAX times.
    always_comb begin
        grant_me = me_elig;
        if (if_elig && (starve_q == STARVE_LIM)) begin
            grant_me = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starve_d    = starve_q;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        if_done_set = 1'b0;
        me_done_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_elig || me_elig) begin
                    state_d = ISSUE;
                    if (grant_me) begin
                        winner_d    = REQ_ME;
                        mem_we_d    = me_we;
                        mem_addr_d  = me_addr[ADDR_W+1:2];
                        mem_wdata_d = me_wdata;
                        if (if_elig && (starve_q < STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        winner_d   = REQ_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr[ADDR_W+1:2];
                        starve_d   = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (winner_q == REQ_IF) begin
                        if_rdata_d  = mem_rdata;
                        if_done_set = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            me_rdata_d = mem_rdata;
                        end
                        me_done_set = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fresh completion wins over the clear so an orphaned transaction still marks done.
    always_comb begin
        if_done_d = stall ? if_done_q : 1'b0;
        me_done_d = stall ? me_done_q : 1'b0;
        if (if_done_set) begin
            if_done_d = 1'b1;
        end
        if (me_done_set) begin
            me_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            winner_q    <= REQ_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            me_done_q   <= 1'b0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            me_done_q   <= me_done_d;
            starve_q    <= starve_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = (state_q == RESP) && (winner_q == REQ_IF);
    assign me_ready  = (state_q == RESP) && (winner_q == REQ_ME);
    assign if_rdata  = if_rdata_q;
    assign me_rdata  = me_rdata_q;

endmodule
